wr_full_gen: RTL and testbench
==============================

WR_FULL_GEN -- requirements
Module: wr_full_gen

Interface
REQ-001 SHALL have parameter ADDRW, default 5, RAM address width (depth 2^ADDRW).
REQ-002 SHALL have parameter AF_THRESH, default 28, fill level at or above which almost_full asserts; range 1..2^ADDRW.
REQ-003 SHALL have port wclk  input  1  write-domain clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wptr  input  ADDRW+1  current binary write pointer from the write-address counter.
REQ-006 SHALL have port we  input  1  write accepted this cycle; pointer increments at the next wclk edge.
REQ-007 SHALL have port rptr_gray  input  ADDRW+1  Gray read pointer, read-clock domain, asynchronous to wclk.
REQ-008 SHALL have port wptr_gray  output  ADDRW+1  registered Gray write pointer for the read-domain synchronizer.
REQ-009 SHALL have port full  output  1  registered FIFO-full flag, fed back to the write-address counter.
REQ-010 SHALL have port almost_full  output  1  registered, level >= AF_THRESH.
REQ-011 SHALL have port wr_level  output  ADDRW+1  registered write-side fill level, 0..2^ADDRW.

Function
REQ-012 SHALL compute wptr_next = wptr + we, modulo 2^(ADDRW+1).
REQ-013 SHALL register wptr_gray <= bin2gray(wptr_next) each wclk edge, so wptr_gray tracks wptr with zero added latency.
REQ-014 SHALL synchronize rptr_gray through two wclk flops (rq1, rq2); no logic between rq1 and rq2.
REQ-015 SHALL register full <= 1 when bin2gray(wptr_next) equals rq2 with its two MSBs inverted and remaining bits equal; else 0.
REQ-016 SHALL register wr_level <= wptr_next - gray2bin(rq2), modulo 2^(ADDRW+1).
REQ-017 SHALL register almost_full <= (wptr_next - gray2bin(rq2)) >= AF_THRESH.
REQ-018 SHALL make full rise on the same edge the write filling the last entry takes effect; no write is ever accepted while full reads 1.
REQ-019 SHALL deassert full exactly 3 wclk edges after a stable rptr_gray change (rq1, rq2, full).
REQ-020 SHALL handle pointer wrap 2^(ADDRW+1)-1 -> 0 without full/level glitch.
REQ-021 SHALL evaluate simultaneous we and rq2 change on the same edge using both new values.
REQ-022 SHALL treat full as pessimistic: stale rq2 may hold full high longer, never assert it late.

Reset
REQ-023 SHALL on rst_n low asynchronously set wptr_gray, rq1, rq2 to bin2gray({1'b1, ADDRW zeros}), matching the pointer reset value on both sides.
REQ-024 SHALL on reset drive full=0, almost_full=0, wr_level=0.
REQ-025 SHALL leave outputs at reset values from assertion until the first wclk edge after release; reset mid-operation discards in-flight synchronizer contents.

Structure
REQ-026 SHALL take ADDRW default and bin2gray/gray2bin functions from shared package fifo_pkg, also used by the read side.
REQ-027 SHALL instantiate sub-module sync_2ff (parameterised width, async reset value) for rq1/rq2, reused by the read-side empty generator.
REQ-028 SHALL contain no combinational path from rptr_gray to any output.

Verification
REQ-029 SHALL cover: after reset, 32 consecutive we=1, rptr_gray static -> full=1 on edge of 32nd write, wr_level=32, almost_full=1 from the 28th write.
REQ-030 SHALL cover: FIFO full, rptr_gray advances one Gray step -> full=0, wr_level=31 exactly 3 wclk edges later.
REQ-031 SHALL cover: wptr running 60..67 with rptr trailing by 4 -> wr_level constant 4, full=0 through wrap 63->0.
REQ-032 SHALL cover: level 31, we=1 on the same edge rq2 advances by one -> level stays 31, full=0.
REQ-033 SHALL cover: rst_n pulsed low mid-burst at level 20 -> full/almost_full/wr_level=0 and wptr_gray=bin2gray(32) immediately, asynchronously.
REQ-034 SHALL cover: random rptr_gray timing vs wclk (async clocks, 3:7 ratio) -> scoreboard proves no write while full and no full with level < 32.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: items shared by the write-side full generator and the
// read-side empty generator of the async FIFO.
//   ADDRW_DEF  default RAM address width (depth 2**ADDRW_DEF)
//   ptr_word_t wide carrier type for the pointer conversion helpers
//   bin2gray / gray2bin  binary <-> reflected Gray conversion; callers
//   zero-extend narrower pointers into ptr_word_t and size-cast the result.
package fifo_pkg;

    localparam int unsigned ADDRW_DEF = 5;
    localparam int unsigned PTR_MAXW  = 32;

    typedef logic [PTR_MAXW-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2(PTR_MAXW) shift steps.
    // Zero-extended inputs keep their upper bits zero.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAXW; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a Gray-coded pointer crossing into
// the clk domain. Shared by the write-side full and read-side empty logic.
//   clk    destination-domain clock
//   rst_n  asynchronous active-low reset; both stages load RST_VAL
//   d      source-domain bus (must change at most one bit at a time)
//   q      synchronized bus, two clk edges behind d
module sync_2ff #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    // No logic between the stages: q1 is given a full period to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wr_full_gen.sv
// wr_full_gen: write-side status generator of an async FIFO.
// Produces the Gray write pointer for the read domain, and the full,
// almost_full and fill-level flags from the synchronized Gray read pointer.
//   wclk        write-domain clock
//   rst_n       asynchronous active-low reset
//   wptr        binary write pointer (ADDRW+1 bits) from the address counter
//   we          write accepted this cycle; wptr advances at the next edge
//   rptr_gray   Gray read pointer from the read clock domain
//   wptr_gray   registered Gray of the next write pointer
//   full        registered full flag, fed back to the address counter
//   almost_full registered, fill level >= AF_THRESH
//   wr_level    registered fill level as seen from the write side
module wr_full_gen
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRW     = ADDRW_DEF,
    parameter int unsigned AF_THRESH = 28
) (
    input  logic             wclk,
    input  logic             rst_n,
    input  logic [ADDRW:0]   wptr,
    input  logic             we,
    input  logic [ADDRW:0]   rptr_gray,
    output logic [ADDRW:0]   wptr_gray,
    output logic             full,
    output logic             almost_full,
    output logic [ADDRW:0]   wr_level
);

    localparam int unsigned    PW        = ADDRW + 1;
    // Both pointers reset to 2**ADDRW so the level starts at zero.
    localparam logic [ADDRW:0] PTR_RST   = PW'(1) << ADDRW;
    localparam logic [ADDRW:0] GRAY_RST  = PW'(bin2gray(ptr_word_t'(PTR_RST)));
    // In Gray code, "one lap ahead" differs exactly in the two MSBs.
    localparam logic [ADDRW:0] FULL_XOR  = PW'(2'b11) << (ADDRW - 1);
    localparam logic [ADDRW:0] AF_LEVEL  = AF_THRESH[ADDRW:0];

    logic [ADDRW:0] rq2;
    logic [ADDRW:0] wptr_next;
    logic [ADDRW:0] wgray_next;
    logic [ADDRW:0] rbin;
    logic [ADDRW:0] level_next;
    logic           full_next;
    logic           af_next;

    sync_2ff #(
        .W       (PW),
        .RST_VAL (GRAY_RST)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (rst_n),
        .d     (rptr_gray),
        .q     (rq2)
    );

    // Flags are computed from the pointer value after this cycle's write so
    // full rises on the very edge that fills the last entry.
    always_comb begin
        wptr_next  = wptr + {{ADDRW{1'b0}}, we};
        wgray_next = PW'(bin2gray(ptr_word_t'(wptr_next)));
        rbin       = PW'(gray2bin(ptr_word_t'(rq2)));
        level_next = wptr_next - rbin;
        full_next  = (wgray_next == (rq2 ^ FULL_XOR));
        af_next    = (level_next >= AF_LEVEL);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_gray   <= GRAY_RST;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wptr_gray   <= wgray_next;
            full        <= full_next;
            almost_full <= af_next;
            wr_level    <= level_next;
        end
    end

endmodule

// File: tb/tb_wr_full_gen.sv
// tb_wr_full_gen: self-checking bench for wr_full_gen.
// The bench owns the write-address counter (gated by full) and the read
// pointer. A scoreboard queue holds the expected outputs of each write-clock
// edge, derived from plain pointer arithmetic: level = writes - reads seen
// through two sync stages, full = (level == 32). Directed vectors come from
// a table; wrap, reset and async-read phases are hand-written sequences.
module tb_wr_full_gen;

    localparam int unsigned PW = 6;

    logic          wclk;
    logic          rclk;
    logic          rst_n;
    logic          we;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;

    int unsigned wcount;   // bench write pointer, unbounded binary
    int unsigned rbin;     // bench read pointer, unbounded binary
    int unsigned h1, h2;   // read pointer as sampled at the last two wclk edges
    int unsigned checks;
    int unsigned errors;
    logic        wdone;
    logic        saw_full;

    typedef struct {
        logic        full;
        logic        af;
        int unsigned lvl;
        int unsigned wg;
    } exp_t;

    typedef struct {
        logic        we;
        int unsigned rbin;
        int unsigned lvl;
        logic        full;
        logic        af;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];

    function automatic logic [PW-1:0] gray6(input int unsigned b);
        int unsigned m;
        m = b & 63;
        return PW'(m ^ (m >> 1));
    endfunction

    function automatic int unsigned bin6(input logic [PW-1:0] g);
        int unsigned b;
        logic        bit_v;
        b     = 0;
        bit_v = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            bit_v = bit_v ^ g[i];
            b     = (b << 1) | (bit_v ? 1 : 0);
        end
        return b;
    endfunction

    assign wptr      = PW'(wcount & 63);
    assign rptr_gray = gray6(rbin);

    wr_full_gen #(
        .ADDRW     (5),
        .AF_THRESH (28)
    ) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .wptr        (wptr),
        .we          (we),
        .rptr_gray   (rptr_gray),
        .wptr_gray   (wptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level)
    );

    // wclk posedges at 15 mod 30, rclk posedges at 7 mod 10: never coincide
    // with a wclk edge or the +1 drive point (3:7 period ratio).
    initial begin
        wclk = 1'b0;
        forever #15 wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        #37;
        forever begin
            rclk = 1'b1;
            #35;
            rclk = 1'b0;
            #35;
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One write-clock cycle. Called just after an edge; drives we, queues
    // the expectation, waits for the next edge and compares.
    task automatic cycle(input logic we_req);
        logic        we_eff;
        int unsigned wnext;
        exp_t        e;
        we_eff = we_req & ~full;
        if (we_eff) check("write_below_full", (wr_level < 32) ? 1 : 0, 1);
        we     = we_eff;
        wnext  = wcount + (we_eff ? 1 : 0);
        e.lvl  = (wnext - h2) & 63;
        e.full = (e.lvl == 32);
        e.af   = (e.lvl >= 28);
        e.wg   = gray6(wnext);
        sbq.push_back(e);
        @(posedge wclk);
        h2 = h1;
        h1 = rbin;
        #1;
        wcount = wnext;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            check("full", full, e.full);
            check("almost_full", almost_full, e.af);
            check("wr_level", wr_level, e.lvl);
            check("wptr_gray", wptr_gray, e.wg);
        end
        if (full) saw_full = 1'b1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    // and hold until the first edge after release.
    task automatic do_reset();
        we    = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_wr_level", wr_level, 0);
        check("rst_wptr_gray", wptr_gray, 48);
        wcount = 32;
        rbin   = 32;
        h1     = 32;
        h2     = 32;
        sbq.delete();
        @(posedge wclk);
        #1;
        rst_n = 1'b1;
        check("rel_wr_level", wr_level, 0);
    endtask

    initial begin
        logic [PW-1:0] ws1, ws2;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        we       = 1'b0;
        wcount   = 32;
        rbin     = 32;
        h1       = 32;
        h2       = 32;
        wdone    = 1'b0;
        saw_full = 1'b0;

        // Fill with static read pointer: full on the 32nd write edge,
        // almost_full from the 28th.
        for (int unsigned i = 1; i <= 32; i++)
            tbl.push_back('{we: 1'b1, rbin: 32, lvl: i, full: (i == 32), af: (i >= 28)});
        // Write requested while full is refused.
        tbl.push_back('{we: 1'b1, rbin: 32, lvl: 32, full: 1'b1, af: 1'b1});
        // One read step: full drops exactly 3 edges later.
        tbl.push_back('{we: 1'b0, rbin: 33, lvl: 32, full: 1'b1, af: 1'b1});
        tbl.push_back('{we: 1'b0, rbin: 33, lvl: 32, full: 1'b1, af: 1'b1});
        tbl.push_back('{we: 1'b0, rbin: 33, lvl: 31, full: 1'b0, af: 1'b1});
        // Level 31, write lands on the edge that sees the next read step.
        tbl.push_back('{we: 1'b0, rbin: 34, lvl: 31, full: 1'b0, af: 1'b1});
        tbl.push_back('{we: 1'b0, rbin: 34, lvl: 31, full: 1'b0, af: 1'b1});
        tbl.push_back('{we: 1'b1, rbin: 34, lvl: 31, full: 1'b0, af: 1'b1});

        #2;
        do_reset();
        for (int unsigned i = 0; i < tbl.size(); i++) begin
            rbin = tbl[i].rbin;
            cycle(tbl[i].we);
            check("tbl_level", wr_level, tbl[i].lvl);
            check("tbl_full", full, tbl[i].full);
            check("tbl_af", almost_full, tbl[i].af);
        end

        // Pointer wrap: read pointer trails so the level settles at 4
        // while wptr runs 60..67 (63 -> 0 in 6 bits).
        do_reset();
        for (int unsigned k = 0; k < 36; k++) begin
            rbin = (wcount - 1 < 32) ? 32 : wcount - 1;
            cycle(1'b1);
            if (wcount >= 60 && wcount <= 67) begin
                check("wrap_level", wr_level, 4);
                check("wrap_full", full, 0);
            end
        end

        // Reset mid-burst at level 20.
        do_reset();
        repeat (20) cycle(1'b1);
        check("pre_reset_level", wr_level, 20);
        do_reset();
        cycle(1'b0);

        // Free-running reader on its own clock against random writes.
        ws1 = wptr_gray;
        ws2 = wptr_gray;
        fork
            begin
                for (int unsigned n = 0; n < 800; n++)
                    cycle($urandom_range(0, 3) != 0);
                wdone = 1'b1;
            end
            begin
                int unsigned wsb;
                while (!wdone) begin
                    @(posedge rclk);
                    wsb = bin6(ws2);
                    ws2 = ws1;
                    ws1 = wptr_gray;
                    if (!wdone && $urandom_range(0, 1) == 1 && (rbin & 63) != wsb)
                        rbin = rbin + 1;
                end
            end
        join
        check("random_full_seen", saw_full, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
